// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the DMA/debug loader port, the
// data memory and the arbiter. The master modport is the arbiter's view,
// the slave modport is the view of the requesters and the memory.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  // CPU port
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_stall;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_rvalid;
  // DMA port
  logic                  dma_req;
  logic                  dma_we;
  logic                  dma_lock;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_gnt;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_rvalid;
  // Data memory port
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares the single-ported DMEM between the CPU MEM
// stage (priority) and the DMA/debug loader port, with DMA starvation
// protection and short locked DMA bursts. At most one access per cycle.
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until its access is performed (CPU: cpu_stall low; DMA: dma_gnt high) in
// that same cycle. Read data returns in the owner's rdata with rvalid high for
// exactly the cycle after the grant; writes produce no rvalid.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8,
  localparam int SW = $clog2(STARVE_LIMIT + 1),
  localparam int BW = $clog2(BURST_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.master bus,
  output logic [1:0]    dbg_st,
  output logic [SW-1:0] dbg_starve_cnt,
  output logic [BW-1:0] dbg_burst_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } st_t;

  localparam logic [SW-1:0] STARVE_LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_MAX_C    = BW'(BURST_MAX);

  st_t           st;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          lock_q;     // dma_lock sampled on the last DMA grant

  logic dma_win;
  logic cpu_win;
  logic lock_active;

  // Grant decision: DMA wins on an active lock, an idle CPU or starvation.
  always_comb begin
    lock_active = (st == ST_DMA) && lock_q && (burst_cnt < BURST_MAX_C);
    dma_win     = bus.dma_req &&
                  (lock_active || !bus.cpu_req || (starve_cnt == STARVE_LIMIT_C));
    cpu_win     = bus.cpu_req && !dma_win;
  end

  // Memory strobe mux and requester status; fields are zero when idle.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (dma_win) begin
      bus.mem_read  = ~bus.dma_we;
      bus.mem_write = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end else if (cpu_win) begin
      bus.mem_read  = ~bus.cpu_we;
      bus.mem_write = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
    bus.cpu_stall = bus.cpu_req & ~cpu_win;
    bus.dma_gnt   = dma_win;
  end

  // Owner state, fairness counters and registered read returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st             <= ST_IDLE;
      starve_cnt     <= '0;
      burst_cnt      <= '0;
      lock_q         <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.dma_rdata  <= '0;
      bus.dma_rvalid <= 1'b0;
    end else begin
      bus.cpu_rvalid <= cpu_win & ~bus.cpu_we;
      bus.dma_rvalid <= dma_win & ~bus.dma_we;
      if (cpu_win && !bus.cpu_we) bus.cpu_rdata <= bus.mem_rdata;
      if (dma_win && !bus.dma_we) bus.dma_rdata <= bus.mem_rdata;

      if (dma_win) begin
        st         <= ST_DMA;
        starve_cnt <= '0;
        lock_q     <= bus.dma_lock;
        if (!bus.dma_lock)
          burst_cnt <= '0;
        else if (burst_cnt != BURST_MAX_C)
          burst_cnt <= burst_cnt + 1'b1;
      end else if (cpu_win) begin
        st        <= ST_CPU;
        burst_cnt <= '0;
        lock_q    <= 1'b0;
        if (!bus.dma_req)
          starve_cnt <= '0;
        else if (starve_cnt != STARVE_LIMIT_C)
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        st         <= ST_IDLE;
        burst_cnt  <= '0;
        lock_q     <= 1'b0;
        starve_cnt <= '0;
      end
    end
  end

  assign dbg_st         = st;
  assign dbg_starve_cnt = starve_cnt;
  assign dbg_burst_cnt  = burst_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter.
module tb_dmem_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_st;
  logic [2:0] dbg_starve_cnt;
  logic [3:0] dbg_burst_cnt;

  int total = 0;
  int bad   = 0;

  dmem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  dmem_arbiter #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .STARVE_LIMIT(4), .BURST_MAX(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_st(dbg_st),
    .dbg_starve_cnt(dbg_starve_cnt),
    .dbg_burst_cnt(dbg_burst_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: set all requester fields and the memory read data at once.
  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca,
                       input logic [15:0] cd, input logic dr, input logic dw,
                       input logic dl, input logic [7:0] da, input logic [15:0] dd,
                       input logic [15:0] mr);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.dma_req   = dr;
    bus.dma_we    = dw;
    bus.dma_lock  = dl;
    bus.dma_addr  = da;
    bus.dma_wdata = dd;
    bus.mem_rdata = mr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_gnt} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000",
                      {bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_gnt});
    end
    total++;
    if ({bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, bus.dma_rdata} !== 34'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0",
                      {bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, bus.dma_rdata});
    end
    total++;
    if ({dbg_st, dbg_starve_cnt, dbg_burst_cnt} !== 9'h0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", {dbg_st, dbg_starve_cnt, dbg_burst_cnt});
    end
  endtask

  task automatic test_cpu_only();
    @(negedge clk);
    drive(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0, 16'h1234);
    #1;
    total++;
    if ({bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_gnt} !== 4'b1000) begin
      bad++; $display("FAIL cpu_strobes got=%b exp=1000",
                      {bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_gnt});
    end
    total++;
    if (bus.mem_addr !== 8'h10) begin
      bad++; $display("FAIL cpu_addr got=%h exp=10", bus.mem_addr);
    end
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 16'h5555);
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'h1234) begin
      bad++; $display("FAIL cpu_rdata got=%b/%h exp=1/1234", bus.cpu_rvalid, bus.cpu_rdata);
    end
    @(posedge clk); #1;
    total++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 16'h1234) begin
      bad++; $display("FAIL cpu_rdata_hold got=%b/%h exp=0/1234", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_dma_only();
    @(negedge clk);
    drive(0, 0, 8'h00, 16'h0, 1, 1, 0, 8'h20, 16'hBEEF, 16'h0);
    #1;
    total++;
    if ({bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_gnt} !== 4'b0101) begin
      bad++; $display("FAIL dma_strobes got=%b exp=0101",
                      {bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_gnt});
    end
    total++;
    if (bus.mem_addr !== 8'h20 || bus.mem_wdata !== 16'hBEEF) begin
      bad++; $display("FAIL dma_bus got=%h/%h exp=20/beef", bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    total++;
    if (bus.dma_rvalid !== 1'b0) begin
      bad++; $display("FAIL dma_write_rvalid got=%b exp=0", bus.dma_rvalid);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 1, 8'h44, 16'h7777, 0, 1, 1, 8'h55, 16'h8888, 16'h0);
      #1;
      total++;
      if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== 26'h0) begin
        bad++; $display("FAIL idle_bus cyc=%0d got=%h exp=0", i,
                        {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata});
      end
    end
    total++;
    if ({dbg_st, dbg_starve_cnt, dbg_burst_cnt} !== 9'h0) begin
      bad++; $display("FAIL idle_state got=%h exp=0", {dbg_st, dbg_starve_cnt, dbg_burst_cnt});
    end
  endtask

  task automatic test_starvation();
    logic [9:0] pat;
    logic [2:0] starve_exp [10];
    pat = 10'b0000100001;
    starve_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    do_reset();
    drive(1, 0, 8'h11, 16'h0, 1, 0, 0, 8'h22, 16'h0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (bus.dma_gnt !== pat[9-i] || bus.cpu_stall !== pat[9-i]) begin
        bad++; $display("FAIL starve_gnt cyc=%0d got=%b/%b exp=%b/%b", i,
                        bus.dma_gnt, bus.cpu_stall, pat[9-i], pat[9-i]);
      end
      total++;
      if (bus.mem_addr !== (pat[9-i] ? 8'h22 : 8'h11) || dbg_starve_cnt !== starve_exp[i]) begin
        bad++; $display("FAIL starve_mux cyc=%0d got=%h/%0d exp=%h/%0d", i, bus.mem_addr,
                        dbg_starve_cnt, pat[9-i] ? 8'h22 : 8'h11, starve_exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst();
    logic [16:0] pat;
    pat = 17'b0000_11111111_0000_1;
    do_reset();
    drive(1, 1, 8'h33, 16'h1111, 1, 1, 1, 8'h66, 16'h2222, 16'h0);
    for (int i = 0; i < 17; i++) begin
      #1;
      total++;
      if (bus.dma_gnt !== pat[16-i] || bus.cpu_stall !== pat[16-i]) begin
        bad++; $display("FAIL burst_gnt cyc=%0d got=%b/%b exp=%b/%b", i,
                        bus.dma_gnt, bus.cpu_stall, pat[16-i], pat[16-i]);
      end
      if (i == 12) begin
        total++;
        if (dbg_burst_cnt !== 4'd8 || dbg_st !== 2'd2) begin
          bad++; $display("FAIL burst_limit got=%0d/%0d exp=8/2", dbg_burst_cnt, dbg_st);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h30, 16'h0, 16'hCAFE);
    @(posedge clk); #1;
    drive(1, 0, 8'h31, 16'h0, 1, 0, 0, 8'h32, 16'h0, 16'h0);
    total++;
    if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 16'hCAFE) begin
      bad++; $display("FAIL mid_dma_read got=%b/%h exp=1/cafe", bus.dma_rvalid, bus.dma_rdata);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 16'h0) begin
      bad++; $display("FAIL async_reset got=%b/%h exp=0/0", bus.dma_rvalid, bus.dma_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.dma_gnt !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_addr !== 8'h31) begin
      bad++; $display("FAIL post_reset_gnt got=%b/%b/%h exp=0/0/31",
                      bus.dma_gnt, bus.cpu_stall, bus.mem_addr);
    end
    @(negedge clk);
    drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    test_reset();
    test_cpu_only();
    test_dma_only();
    test_idle();
    test_starvation();
    test_burst();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
